rr_arbiter_4: RTL and testbench

//   Round-robin burst arbiter for four sources sharing one n-bit datapath.

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_pick4.sv | 20 ++
 rtl/rr_arbiter_4.sv | 93 +++++++++
 tb/tb_rr_arbiter_4.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-source round-robin burst arbiter.
package arb_pkg;

  localparam int NUM_SRC = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [3:0] idx2onehot(input logic [1:0] idx);
    idx2onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set req bit scanning ptr, ptr+1, ... mod 4.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         ptr,
  output logic [1:0]         idx,
  output logic               vld
);

  // Scan from the farthest candidate back to ptr so the closest one wins.
  always_comb begin
    idx = '0;
    vld = |req;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) idx = ptr + 2'(k);
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin burst arbiter: owns one grant per burst, rotates priority at burst end.
// Handshake: a beat moves when en & req[sel] & out_ready; req must stay high for the burst.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CW       = $clog2(HOLD_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] last,
  input  logic               out_ready,
  output logic [NUM_SRC-1:0] gnt,
  output logic [1:0]         sel,
  output logic               en,
  output logic               beat,
  output arb_state_t         dbg_state
);

  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  arb_state_t         r_state;
  logic [NUM_SRC-1:0] r_gnt;
  logic [1:0]         r_sel;
  logic               r_en;
  logic [1:0]         r_ptr;
  logic [CW-1:0]      r_cnt;

  logic               w_beat;
  logic               w_last_beat;
  logic               w_end;
  logic [NUM_SRC-1:0] w_pick_req;
  logic [1:0]         w_pick_ptr;
  logic [1:0]         w_idx;
  logic               w_vld;

  assign w_beat      = r_en & req[r_sel] & out_ready;
  assign w_last_beat = w_beat & (last[r_sel] | (r_cnt == CNT_LAST));
  assign w_end       = (r_state == GRANT) & (~req[r_sel] | w_last_beat);

  // At burst end the current owner is masked out and scanning starts just past it.
  assign w_pick_req = (r_state == GRANT) ? (req & ~idx2onehot(r_sel)) : req;
  assign w_pick_ptr = (r_state == GRANT) ? (r_sel + 2'd1) : r_ptr;

  rr_pick4 u_pick (
    .req (w_pick_req),
    .ptr (w_pick_ptr),
    .idx (w_idx),
    .vld (w_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_en    <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else if (r_state == IDLE) begin
      if (w_vld) begin
        r_state <= GRANT;
        r_gnt   <= idx2onehot(w_idx);
        r_sel   <= w_idx;
        r_en    <= 1'b1;
        r_cnt   <= '0;
      end
    end else begin
      if (w_end) begin
        r_ptr <= r_sel + 2'd1;
        if (w_vld) begin
          r_gnt <= idx2onehot(w_idx);
          r_sel <= w_idx;
          r_cnt <= '0;
        end else begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_en    <= 1'b0;
        end
      end else if (w_beat) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign en        = r_en;
  assign beat      = w_beat;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: vector table plus hand-written burst sequences.
module tb_rr_arbiter_4;
  import arb_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] req, last, req_b, last_b;
  logic       out_ready, rdy_b;
  logic [3:0] gnt, gnt_b;
  logic [1:0] sel, sel_b;
  logic       en, en_b, beat, beat_b;
  arb_state_t dbg_state, state_b;

  int total = 0;
  int bad   = 0;

  logic [5:0] exp_q[$];

  rr_arbiter_4 u_dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .out_ready(out_ready),
    .gnt(gnt), .sel(sel), .en(en), .beat(beat), .dbg_state(dbg_state)
  );

  rr_arbiter_4 #(.HOLD_MAX(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req_b), .last(last_b), .out_ready(rdy_b),
    .gnt(gnt_b), .sel(sel_b), .en(en_b), .beat(beat_b), .dbg_state(state_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // drive inputs, compare at negedge, advance past the next rising edge
  task automatic cyc_a(input string tag, input logic r, input logic [3:0] rq, input logic [3:0] ls,
                       input logic rd, input logic [3:0] eg, input logic [1:0] es,
                       input logic ee, input logic eb);
    rst = r; req = rq; last = ls; out_ready = rd;
    @(negedge clk);
    chk({tag, ".gnt"},   gnt,              eg);
    chk({tag, ".sel"},   4'(sel),          4'(es));
    chk({tag, ".en"},    4'(en),           4'(ee));
    chk({tag, ".beat"},  4'(beat),         4'(eb));
    chk({tag, ".state"}, 4'(dbg_state),    4'(ee));
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input string tag, input logic [3:0] rq, input logic [3:0] ls,
                       input logic rd, input logic [3:0] eg, input logic [1:0] es);
    req_b = rq; last_b = ls; rdy_b = rd;
    @(negedge clk);
    chk({tag, ".gnt"},  gnt_b,       eg);
    chk({tag, ".sel"},  4'(sel_b),   4'(es));
    chk({tag, ".en"},   4'(en_b),    4'(|eg));
    chk({tag, ".beat"}, 4'(beat_b),  4'(|eg));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       en;
    logic       beat;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int beats;
    int c;
    logic rd;
    logic [5:0] e;

    // rst, req, last, rdy | gnt, sel, en, beat
    vecs[0]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h2, 2'd1, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h4, 2'd2, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h8, 2'd3, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h2, 2'd1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 2'd1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'h3, 4'h0, 1'b1, 4'h0, 2'd1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'h3, 4'h1, 1'b0, 4'h1, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'h3, 4'h1, 1'b1, 4'h1, 2'd0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 4'h2, 4'h2, 1'b1, 4'h2, 2'd1, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 4'h2, 4'h2, 1'b1, 4'h0, 2'd1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'h2, 4'h2, 1'b1, 4'h2, 2'd1, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 2'd1, 1'b0, 1'b0};

    rst = 1'b1; req = 4'hF; last = 4'h0; out_ready = 1'b1;
    req_b = 4'h0; last_b = 4'h0; rdy_b = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++)
      cyc_a($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].last, vecs[i].rdy,
            vecs[i].gnt, vecs[i].sel, vecs[i].en, vecs[i].beat);

    // src2 five-beat burst under toggling backpressure, ptr starts at 2
    cyc_a("bp_req", 1'b0, 4'h4, 4'h0, 1'b1, 4'h0, 2'd1, 1'b0, 1'b0);
    beats = 0;
    c = 0;
    while (beats < 5 && c < 20) begin
      rd = (c % 2 == 0);
      cyc_a($sformatf("bp_c%0d", c), 1'b0, 4'h4, (beats == 4) ? 4'h4 : 4'h0, rd,
            4'h4, 2'd2, 1'b1, rd);
      if (rd) beats++;
      c++;
    end
    chk("bp_beats", 4'(beats), 4'd5);
    cyc_a("bp_release", 1'b0, 4'h4, 4'h0, 1'b1, 4'h0, 2'd2, 1'b0, 1'b0);
    cyc_a("bp_regrant", 1'b0, 4'h4, 4'h0, 1'b0, 4'h4, 2'd2, 1'b1, 1'b0);
    cyc_a("bp_drop",    1'b0, 4'h0, 4'h0, 1'b1, 4'h4, 2'd2, 1'b1, 1'b0);

    // abandon to idle; ptr must land on 1
    cyc_a("ab_idle", 1'b0, 4'h1, 4'h0, 1'b1, 4'h0, 2'd2, 1'b0, 1'b0);
    cyc_a("ab_gnt0", 1'b0, 4'h0, 4'h0, 1'b1, 4'h1, 2'd0, 1'b1, 1'b0);
    cyc_a("ab_gone", 1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
    cyc_a("ab_ptr1", 1'b0, 4'h8, 4'h0, 1'b1, 4'h2, 2'd1, 1'b1, 1'b0);

    // reset during src3 beat 2
    cyc_a("mb_beat1",  1'b0, 4'h8, 4'h0, 1'b1, 4'h8, 2'd3, 1'b1, 1'b1);
    cyc_a("mb_beat2",  1'b1, 4'h8, 4'h0, 1'b1, 4'h8, 2'd3, 1'b1, 1'b1);
    cyc_a("mb_after",  1'b0, 4'hF, 4'h0, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0);
    cyc_a("mb_src0",   1'b0, 4'hF, 4'h0, 1'b1, 4'h1, 2'd0, 1'b1, 1'b1);

    // hold limit 4: src1 and src3 stream with no last
    exp_q.push_back({4'h0, 2'd0});
    for (int i = 0; i < 4; i++) exp_q.push_back({4'h2, 2'd1});
    for (int i = 0; i < 4; i++) exp_q.push_back({4'h8, 2'd3});
    for (int i = 0; i < 2; i++) exp_q.push_back({4'h2, 2'd1});
    c = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc_b($sformatf("hl_c%0d", c), 4'hA, 4'h0, 1'b1, e[5:2], e[1:0]);
      c++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
